// File: rtl/bg_pkg.sv
// Shared constants, types and address helper for the background tile fetch path.
package bg_pkg;

    localparam int TILE_COLS      = 20;
    localparam int TILE_ROWS      = 15;
    localparam int TILE_PX        = 32;
    localparam int TILES_PER_ROOM = 300;
    localparam int CODE_W         = 2;
    localparam int ROOM_W         = 2;
    localparam int MAP_AW         = 11;
    localparam int COL_W          = 5;
    localparam int ROW_W          = 4;

    typedef logic [CODE_W-1:0] tile_code_t;

    typedef enum tile_code_t {
        TILE_FLOOR = 2'd0,
        TILE_WALL  = 2'd1
    } tile_kind_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2
    } fetch_state_t;

    // Tile-map address of column 0 of a given row within a room.
    function automatic logic [MAP_AW-1:0] map_base(input logic [ROOM_W-1:0] room,
                                                   input logic [ROW_W-1:0]  row);
        return MAP_AW'(room) * MAP_AW'(TILES_PER_ROOM) + MAP_AW'(row) * MAP_AW'(TILE_COLS);
    endfunction

endpackage

// File: rtl/bg_tile_fetcher_line_buffer.sv
// One tile row of codes: synchronous write and clear, asynchronous read.
module tile_line_buffer
    import bg_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [COL_W-1:0] wr_col,
    input  tile_code_t       wr_data,
    input  logic [COL_W-1:0] rd_col,
    output tile_code_t       rd_data
);

    tile_code_t mem [TILE_COLS];

    // Clear has priority so nothing in flight can land after a reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < TILE_COLS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_col < COL_W'(TILE_COLS))) begin
            mem[wr_col] <= wr_data;
        end
    end

    // Columns past the last tile read as floor.
    always_comb begin
        rd_data = '0;
        if (rd_col < COL_W'(TILE_COLS)) begin
            rd_data = mem[rd_col];
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/bg_tile_fetcher.sv
// Per-scanline background tile fetcher: loads one tile row from the map RAM
// during hblank and serves the per-pixel tile code during active video.
module bg_tile_fetcher
    import bg_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [ROOM_W-1:0] room_sel,
    output logic [MAP_AW-1:0] map_addr,
    output logic              map_rd,
    input  tile_code_t        map_data,
    output tile_code_t        tile_code,
    output logic              tile_valid,
    output logic              busy,
    output logic              overrun,
    output logic [ROOM_W-1:0] room_active
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(TILE_COLS - 1);

    fetch_state_t      state;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  wr_col;
    logic              wr_en;
    logic              fetch_req;
    logic [ROW_W-1:0]  fetch_row;
    logic [ROOM_W-1:0] fetch_room;
    tile_code_t        rd_data;

    // Rows 1..14 are fetched on the last line of the preceding tile row (DrawY = 32r-1).
    always_comb begin
        fetch_req  = line_start && (DrawY[4:0] == 5'd31) && (DrawY[9:5] < 5'd14);
        fetch_row  = DrawY[8:5] + 4'd1;
        fetch_room = frame_start ? room_sel : room_active;
    end

    // Fetch sequencer; wr_en/wr_col trail map_rd/col by one cycle to meet the RAM latency.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            map_rd      <= 1'b0;
            map_addr    <= '0;
            col         <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            room_active <= '0;
            wr_en       <= 1'b0;
            wr_col      <= '0;
        end else begin
            wr_en  <= map_rd;
            wr_col <= col;
            if (frame_start) begin
                room_active <= room_sel;
            end
            if (line_start && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        state    <= FETCH;
                        map_rd   <= 1'b1;
                        map_addr <= map_base(fetch_room, fetch_row);
                        col      <= '0;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (col == LAST_COL) begin
                        state  <= LAST;
                        map_rd <= 1'b0;
                    end else begin
                        col      <= col + 5'd1;
                        map_addr <= map_addr + 11'd1;
                    end
                end
                LAST: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    map_rd <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    tile_line_buffer u_line_buffer (
        .clk     (Clk),
        .clr     (Reset),
        .wr_en   (wr_en),
        .wr_col  (wr_col),
        .wr_data (map_data),
        .rd_col  (DrawX[9:5]),
        .rd_data (rd_data)
    );

    // Active tile area excludes the status-bar row and everything outside 640x480.
    always_comb begin
        tile_valid = (DrawY >= 10'(TILE_PX)) && (DrawY < 10'(TILE_ROWS * TILE_PX)) &&
                     (DrawX < 10'(TILE_COLS * TILE_PX));
        tile_code  = tile_valid ? rd_data : '0;
    end

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Scoreboard bench for bg_tile_fetcher: stimulus pushes expected reads and tile
// codes computed from the tile-map rules; a negedge monitor pops and compares.
module tb_bg_tile_fetcher;
    import bg_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [1:0]  room_sel = 2'd0;
    logic [10:0] map_addr;
    logic        map_rd;
    logic [1:0]  map_data;
    logic [1:0]  tile_code;
    logic        tile_valid;
    logic        busy;
    logic        overrun;
    logic [1:0]  room_active;

    always #5 Clk = ~Clk;

    bg_tile_fetcher dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .line_start  (line_start),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .room_sel    (room_sel),
        .map_addr    (map_addr),
        .map_rd      (map_rd),
        .map_data    (map_data),
        .tile_code   (tile_code),
        .tile_valid  (tile_valid),
        .busy        (busy),
        .overrun     (overrun),
        .room_active (room_active)
    );

    // Tile-map RAM with one cycle read latency.
    logic [1:0] ram [2048];
    always @(posedge Clk) map_data <= ram[map_addr];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Reference model state.
    typedef struct { int c; int a; } rd_t;
    rd_t        addr_q[$];
    logic [2:0] tc_q[$];
    int         m_room = 0;
    int         busy_lo = 1;
    int         busy_hi = 0;
    bit         m_ovr = 1'b0;
    logic [1:0] m_buf [20];
    bit         probe = 1'b0;
    bit         mon_en = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic bit m_busy(int c);
        return (c >= busy_lo) && (c <= busy_hi);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Drive one cycle of frame_start/line_start and update the model.
    task automatic pulse(bit fs, bit ls, int y);
        int row;
        int base;
        frame_start = fs;
        line_start  = ls;
        DrawY       = 10'(y);
        if (fs) m_room = int'(room_sel);
        if (ls) begin
            row = (y + 1) / 32;
            if (m_busy(cyc)) begin
                m_ovr = 1'b1;
            end else if (((y + 1) % 32 == 0) && row >= 1 && row <= 14) begin
                base = m_room * 300 + row * 20;
                for (int c = 0; c < 20; c++) begin
                    addr_q.push_back('{cyc + 1 + c, base + c});
                    m_buf[c] = ram[base + c];
                end
                busy_lo = cyc + 1;
                busy_hi = cyc + 21;
            end
        end
        step();
        frame_start = 1'b0;
        line_start  = 1'b0;
    endtask

    task automatic probe_at(int x, int y);
        bit         v;
        logic [1:0] code;
        DrawX = 10'(x);
        DrawY = 10'(y);
        v     = (y >= 32) && (y < 480) && (x < 640);
        code  = v ? m_buf[x / 32] : 2'd0;
        tc_q.push_back({v, code});
        probe = 1'b1;
        step();
        probe = 1'b0;
    endtask

    task automatic probe_row(int y);
        for (int c = 0; c < 20; c++) probe_at(c * 32 + $urandom_range(0, 31), y);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        if (busy_hi > cyc) busy_hi = cyc;
        while (addr_q.size() > 0 && addr_q[addr_q.size() - 1].c > cyc) void'(addr_q.pop_back());
        m_ovr  = 1'b0;
        m_room = 0;
        foreach (m_buf[i]) m_buf[i] = 2'd0;
        step();
        Reset = 1'b0;
    endtask

    task automatic wait_idle();
        while (m_busy(cyc)) step();
    endtask

    // Monitor: busy every cycle, each map_rd against the expected read queue, probes against tile queue.
    always @(negedge Clk) begin
        bit         exp_rd;
        logic [2:0] e;
        if (mon_en) begin
            exp_rd = (addr_q.size() > 0) && (addr_q[0].c == cyc);
            chk("busy", int'(busy), int'(m_busy(cyc)));
            chk("map_rd", int'(map_rd), int'(exp_rd));
            if (map_rd && exp_rd) chk("map_addr", int'(map_addr), addr_q[0].a);
            if (exp_rd) void'(addr_q.pop_front());
            if (probe) begin
                if (tc_q.size() == 0) begin
                    chk("probe_queue", 0, 1);
                end else begin
                    e = tc_q.pop_front();
                    chk("tile_valid", int'(tile_valid), int'(e[2]));
                    chk("tile_code", int'(tile_code), int'(e[1:0]));
                end
            end
        end
    end

    initial begin
        for (int a = 0; a < 2048; a++) ram[a] = 2'(a);
        foreach (m_buf[i]) m_buf[i] = 2'd0;
        Reset = 1'b1;
        step(3);
        Reset  = 1'b0;
        mon_en = 1'b1;

        chk("reset_room_active", int'(room_active), 0);
        chk("reset_overrun", int'(overrun), 0);
        chk("reset_map_addr", int'(map_addr), 0);
        probe_at(50, 100);

        // Room 2, row 1 fetch: addresses 620..639.
        room_sel = 2'd2;
        pulse(1'b1, 1'b0, 520);
        step(2);
        pulse(1'b0, 1'b1, 31);
        step(25);
        chk("room_active_2", int'(room_active), 2);
        probe_at(96, 32);
        probe_row(32);
        probe_at(639, 40);
        probe_at(640, 40);
        probe_at(96, 31);
        probe_at(96, 479);
        probe_at(96, 480);

        // Mid-frame room change is held off until frame_start.
        DrawY    = 10'd200;
        room_sel = 2'd1;
        step(3);
        chk("room_hold", int'(room_active), 2);
        pulse(1'b0, 1'b1, 31);
        step(25);
        chk("room_hold2", int'(room_active), 2);
        pulse(1'b1, 1'b1, 31);
        step(25);
        chk("room_active_1", int'(room_active), 1);
        probe_row(50);

        // Overrun: second line_start five cycles into a fetch.
        chk("overrun_clear", int'(overrun), 0);
        pulse(1'b0, 1'b1, 63);
        step(4);
        pulse(1'b0, 1'b1, 95);
        chk("overrun_set", int'(overrun), 1);
        step(25);
        chk("overrun_sticky", int'(overrun), 1);
        probe_row(64);

        // Non-qualifying lines, then row 14.
        pulse(1'b0, 1'b1, 30);
        step(3);
        pulse(1'b0, 1'b1, 479);
        step(3);
        pulse(1'b0, 1'b1, 524);
        step(3);
        pulse(1'b0, 1'b1, 447);
        step(25);
        probe_row(448);

        // Randomized traffic.
        for (int it = 0; it < 80; it++) begin
            int y;
            room_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) y = 32 * $urandom_range(1, 14) - 1;
            else y = $urandom_range(0, 524);
            if (!m_busy(cyc) && $urandom_range(0, 3) == 0) begin
                for (int a = 0; a < 2048; a++) ram[a] = 2'($urandom);
            end
            pulse($urandom_range(0, 2) == 0, 1'b1, y);
            step($urandom_range(0, 30));
            if (!m_busy(cyc)) begin
                repeat (3) probe_at($urandom_range(0, 799), $urandom_range(0, 524));
            end
        end
        chk("overrun_random", int'(overrun), int'(m_ovr));
        chk("room_random", int'(room_active), m_room);

        // Reset at t0+10 of a fetch.
        wait_idle();
        pulse(1'b0, 1'b1, 127);
        step(9);
        do_reset();
        chk("rst_map_rd", int'(map_rd), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_room", int'(room_active), 0);
        probe_row(140);
        step(15);
        probe_row(300);

        step(2);
        chk("reads_drained", addr_q.size(), 0);
        chk("probes_drained", tc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
